// File: rtl/seq_match_ctrl.sv
// Word-to-serial controller with a programmable pattern matcher and match counter.
// Build option: define SEQ_MATCH_OVERLAP_EN to keep match history after a hit (overlapping detection).
module seq_match_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              bit_x,
  output logic              bit_vld,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

`ifdef SEQ_MATCH_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic [1:0]        state;
  logic [PAT_W-1:0]  pat_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  thresh_q;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [PAT_W-1:0]  hist;
  logic [LEN_W-1:0]  bits_seen;

  logic [LEN_W-1:0]  len_clamped;
  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  len_mask;
  logic              hit;
  logic              cnt_max;
  logic [CNT_W-1:0]  cnt_inc;

  // A zero or oversized length means "use the full pattern width".
  assign len_clamped = (cfg_len == '0 || cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

  // The window is also the next history value: newest bit enters at bit 0.
  assign window   = {hist[PAT_W-2:0], shreg[WORD_W-1]};
  assign len_mask = {PAT_W{1'b1}} >> (LEN_W'(PAT_W) - len_q);
  assign hit      = (state == SHIFT)
                  && (((window ^ pat_q) & len_mask) == '0)
                  && (bits_seen >= len_q - LEN_W'(1));
  assign cnt_max  = (match_cnt == {CNT_W{1'b1}});
  assign cnt_inc  = match_cnt + CNT_W'(1);

  assign in_ready = (state == LOAD);
  assign bit_vld  = (state == SHIFT);
  assign bit_x    = bit_vld & shreg[WORD_W-1];
  assign busy     = (state == LOAD) || (state == SHIFT);
  assign done     = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= LEN_W'(PAT_W);
      thresh_q  <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      hist      <= '0;
      bits_seen <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              pat_q     <= cfg_pattern;
              len_q     <= len_clamped;
              thresh_q  <= cfg_thresh;
              match_cnt <= '0;
              hist      <= '0;
              bits_seen <= '0;
              state     <= LOAD;
            end
          end
          LOAD: begin
            if (in_valid) begin
              shreg   <= in_data;
              bit_idx <= '0;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            shreg     <= shreg << 1;
            bit_idx   <= bit_idx + IDX_W'(1);
            hist      <= window;
            bits_seen <= (bits_seen == LEN_W'(PAT_W)) ? bits_seen : bits_seen + LEN_W'(1);
            if (bit_idx == IDX_W'(WORD_W - 1)) state <= LOAD;
            if (hit) begin
              match <= 1'b1;
              if (!cnt_max) match_cnt <= cnt_inc;
              // Reaching the threshold overrides the end-of-word return to LOAD.
              if (thresh_q != '0 && !cnt_max && cnt_inc == thresh_q) state <= DONE;
              if (!OVERLAP) begin
                hist      <= '0;
                bits_seen <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl: expected match events are queued by the stimulus
// and checked by an independent monitor; expectations follow SEQ_MATCH_OVERLAP_EN.
module tb_seq_match_ctrl;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 8;
  localparam int LEN_W  = $clog2(PAT_W + 1);

`ifdef SEQ_MATCH_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [CNT_W-1:0]  cfg_thresh = '0;
  logic              in_valid = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_ready, bit_x, bit_vld, match, busy, done;
  logic [CNT_W-1:0]  match_cnt;

  seq_match_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_thresh(cfg_thresh),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bit_x(bit_x), .bit_vld(bit_vld), .match(match), .match_cnt(match_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;  // 1-based bit ordinal since start of the completing bit
    int cnt;  // match_cnt expected when the pulse is visible
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   bits_total = 0;
  bit   sb_en = 1'b1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_exp(input int pos, input int cnt);
    exp_t e;
    e.pos = pos;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!clr) begin
      bits_total = 0;
    end else begin
      if (start && !stop && !busy) bits_total = 0;
      if (match && sb_en) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_match: pulse after bit %0d with match_cnt %0d, none queued",
                   bits_total, match_cnt);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("match_pos", bits_total, e.pos);
          check("match_cnt_at_pulse", int'(match_cnt), e.cnt);
        end
      end
      if (bit_vld) bits_total++;
    end
  end

  task automatic start_run(input logic [PAT_W-1:0] pat, input int len, input int thr);
    @(posedge clk); #1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_thresh  = CNT_W'(thr);
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  // Returns #1 after the accepting edge, i.e. inside the first bit cycle.
  task automatic send_word(input logic [WORD_W-1:0] data);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        got = 1'b1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    check("word_accepted", int'(got), 1);
  endtask

  task automatic do_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_match_cnt", int'(match_cnt), 0);
    @(posedge clk); #1;
    clr = 1'b1;

    // clr asserted mid-SHIFT with a non-zero count
    sb_en = 1'b0;
    start_run(4'b0011, 2, 0);
    send_word(8'hFF);
    repeat (4) @(posedge clk);
    #1;
    check("pre_clr_busy", int'(busy), 1);
    check("pre_clr_cnt_nonzero", int'(match_cnt != 0), 1);
    clr = 1'b0;
    #1;
    check("clr_in_ready", int'(in_ready), 0);
    check("clr_bit_x", int'(bit_x), 0);
    check("clr_bit_vld", int'(bit_vld), 0);
    check("clr_match", int'(match), 0);
    check("clr_match_cnt", int'(match_cnt), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_done", int'(done), 0);
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check("post_clr_in_ready", int'(in_ready), 0);
    check("post_clr_busy", int'(busy), 0);
    sb_en = 1'b1;

    // Pattern 1011 over word B6 = 1,0,1,1,0,1,1,0
    start_run(4'b1011, 4, 0);
    push_exp(4, 1);
    if (OVL) push_exp(7, 2);
    send_word(8'hB6);
    repeat (WORD_W + 2) @(negedge clk);
    check("b6_drained", q.size(), 0);
    check("b6_final_cnt", int'(match_cnt), OVL ? 2 : 1);
    check("b6_back_in_load", int'(in_ready), 1);
    do_stop();
    check("b6_stop_busy", int'(busy), 0);
    check("b6_stop_cnt_held", int'(match_cnt), OVL ? 2 : 1);

    // Pattern 11 over FF: overlap hits on bits 2..8, otherwise on 2,4,6,8
    start_run(4'b0011, 2, 0);
    if (OVL) for (int i = 2; i <= 8; i++) push_exp(i, i - 1);
    else     for (int i = 1; i <= 4; i++) push_exp(2 * i, i);
    send_word(8'hFF);
    repeat (WORD_W + 2) @(negedge clk);
    check("ff_drained", q.size(), 0);
    check("ff_final_cnt", int'(match_cnt), OVL ? 7 : 4);
    do_stop();

    // Match spanning words: last bit of 01 then 0,1,1 of 60 completes at bit index 2 of word 2
    start_run(4'b1011, 4, 0);
    push_exp(WORD_W + 3, 1);
    send_word(8'h01);
    send_word(8'h60);
    repeat (WORD_W + 2) @(negedge clk);
    check("span_drained", q.size(), 0);
    check("span_final_cnt", int'(match_cnt), 1);
    do_stop();

    // Threshold 1 with pattern 11 over C0: DONE after bit 2
    start_run(4'b0011, 2, 1);
    push_exp(2, 1);
    send_word(8'hC0);
    @(negedge clk);
    check("thr_bit1_vld", int'(bit_vld), 1);
    check("thr_bit1_done", int'(done), 0);
    @(negedge clk);
    check("thr_bit2_vld", int'(bit_vld), 1);
    check("thr_bit2_done", int'(done), 0);
    @(negedge clk);
    check("thr_done_rise", int'(done), 1);
    check("thr_bit_vld_drop", int'(bit_vld), 0);
    check("thr_in_ready", int'(in_ready), 0);
    check("thr_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("thr_done_held", int'(done), 1);
    check("thr_in_ready_held", int'(in_ready), 0);
    check("thr_cnt", int'(match_cnt), 1);
    start_run(4'b0011, 2, 1);
    @(negedge clk);
    check("restart_done_clr", int'(done), 0);
    check("restart_cnt_clr", int'(match_cnt), 0);
    check("restart_in_ready", int'(in_ready), 1);
    do_stop();

    // stop during SHIFT of F0 (issued in the bit-6 cycle), then start+stop in IDLE
    start_run(4'b0011, 2, 0);
    if (OVL) begin
      push_exp(2, 1); push_exp(3, 2); push_exp(4, 3);
    end else begin
      push_exp(2, 1); push_exp(4, 2);
    end
    send_word(8'hF0);
    repeat (5) @(posedge clk);
    #1;
    check("stop_in_shift", int'(bit_vld), 1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_in_ready", int'(in_ready), 0);
    check("stop_bit_vld", int'(bit_vld), 0);
    check("stop_cnt_held", int'(match_cnt), OVL ? 3 : 2);
    @(posedge clk); #1;
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    check("startstop_busy", int'(busy), 0);
    check("startstop_in_ready", int'(in_ready), 0);
    check("startstop_cnt_held", int'(match_cnt), OVL ? 3 : 2);
    check("final_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
